clock_node_freq_sequencer: RTL and testbench
============================================

CLOCK_NODE_FREQ_SEQUENCER -- requirements
Module: clock_node_freq_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port: async_resetn  input  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have port: node_setting  input  32  bit0 = enable, bits[15:8] = settle cycle count, other bits ignored.
REQ-004 SHALL have port: node_frequency_override  input  32  requested target frequency in Hz.
REQ-005 SHALL have port: node_minfrequency  input  32  lowest legal target in Hz.
REQ-006 SHALL have port: node_maxfrequency  input  32  highest legal target in Hz.
REQ-007 SHALL have port: parent_frequency  input  32  parent clock frequency in Hz; sampled in CHECK.
REQ-008 SHALL have port: div_ack  input  1  divider has accepted div_value.
REQ-009 SHALL have port: div_value  output  16  integer divide ratio for the clock divider.
REQ-010 SHALL have port: div_load  output  1  div_value is valid; held until div_ack.
REQ-011 SHALL have port: node_frequency  output  32  currently applied frequency in Hz.
REQ-012 SHALL have port: node_frequency_setting  output  32  last accepted target in Hz.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port: error  output  1  sticky flag for a rejected request.

Function
REQ-015 SHALL implement the FSM states IDLE, CHECK, DIVIDE, LOAD and SETTLE.
REQ-016 SHALL hold an internal last_override register.
REQ-017 SHALL, in IDLE, when node_setting[0]=1 and node_frequency_override != last_override, capture the target, set last_override to the target, and go to CHECK on the next edge.
REQ-018 SHALL, in CHECK (one cycle), reject the request when target==0, target<node_minfrequency, target>node_maxfrequency, or target>parent_frequency (all comparisons unsigned 32-bit).
REQ-019 SHALL, on rejection, set error=1, return to IDLE, and leave div_value, node_frequency and node_frequency_setting unchanged.
REQ-020 SHALL, on acceptance, set node_frequency_setting=target and go to DIVIDE.
REQ-021 SHALL, in DIVIDE, compute quotient = parent_frequency / target (truncating) with a restoring divider resolving one bit per cycle, taking exactly 32 cycles.
REQ-022 SHALL, at the end of DIVIDE, set error=1 and go to IDLE if quotient > 65535; otherwise it SHALL latch div_value = quotient[15:0] and go to LOAD.
REQ-023 SHALL, in LOAD, hold div_load=1 with div_value stable and stay in LOAD until div_ack=1 is sampled.
REQ-024 SHALL, on sampling div_ack=1, deassert div_load on the same edge.
REQ-025 SHALL ignore div_ack outside LOAD.
REQ-026 SHALL, in SETTLE, wait N = node_setting[15:8] cycles, where N is sampled on SETTLE entry.
REQ-027 SHALL, when N=0, spend one cycle in SETTLE.
REQ-028 SHALL, on leaving SETTLE, set node_frequency=target, clear error, and return to IDLE.
REQ-029 SHALL ignore changes to node_frequency_override while busy; the value present on return to IDLE is compared against last_override, so the latest value wins and intermediate values are dropped.
REQ-030 SHALL sample node_setting[0] only in IDLE; clearing it mid-sequence SHALL NOT abort the sequence.
REQ-031 SHALL, on a request, first evaluate busy=1 in the cycle after the IDLE acceptance edge.
REQ-032 SHALL have a best-case latency from the accept edge to node_frequency update of 1 (CHECK) + 32 (DIVIDE) + 1 (LOAD with immediate ack) + max(N,1) (SETTLE) cycles.

Reset
REQ-033 SHALL, while async_resetn=0 and regardless of state, immediately force state=IDLE, last_override=0, div_value=16'd1, div_load=0, node_frequency=0, node_frequency_setting=0, busy=0, error=0, and clear the divider and settle counter.
REQ-034 SHALL, after reset release, act on no request until the first rising edge with enable=1 and override != 0.

Verification
REQ-035 SHALL verify: parent=100000000, min=1000000, max=50000000, override=25000000, enable=1, N=4, ack after 2 cycles -> div_load rises 33 cycles after accept; div_value=4; node_frequency=25000000 after SETTLE; busy low for one cycle.
REQ-036 SHALL verify: override=60000000 with max=50000000 -> error=1 after CHECK; div_load never asserted; node_frequency and div_value unchanged.
REQ-037 SHALL verify: parent=100000000, override=1000, min=1 -> quotient 100000 > 65535; error=1 after DIVIDE; div_value remains 1.
REQ-038 SHALL verify: while in DIVIDE, override changes 20000000 -> 10000000 -> 12500000 -> after completion, a second sequence starts for 12500000 only, giving div_value=8.
REQ-039 SHALL verify: div_ack held low for 100 cycles in LOAD -> div_load and div_value stable for all 100 cycles; the sequence completes 1+N cycles after ack.
REQ-040 SHALL verify: async_resetn pulsed low mid-DIVIDE -> all outputs take their reset values immediately; after release with override unchanged, a new sequence starts (last_override was cleared).

Source files
------------

// File: rtl/clock_node_freq_sequencer_if.sv
// Divider handshake bundle between the frequency sequencer and the clock divider.
// The sequencer drives a divide ratio with a load strobe. The divider answers
// with an acknowledge once it has taken the ratio.
interface clock_node_freq_sequencer_if;
   logic [15:0] div_value;
   logic        div_load;
   logic        div_ack;

   modport master (
      output div_value,
      output div_load,
      input  div_ack
   );

   modport slave (
      input  div_value,
      input  div_load,
      output div_ack
   );
endinterface

// File: rtl/clock_node_freq_sequencer.sv
// Clock node frequency sequencer.
// A new override target is validated against the min/max/parent limits.
// The divide ratio parent/target is then found with a 32-step restoring divider.
// The ratio is handed to the clock divider over a load/ack handshake, followed by
// a programmable settle time. After that, the new frequency is reported as applied.
module clock_node_freq_sequencer (
   input  logic                              clock,
   input  logic                              async_resetn,
   input  logic [31:0]                       node_setting,
   input  logic [31:0]                       node_frequency_override,
   input  logic [31:0]                       node_minfrequency,
   input  logic [31:0]                       node_maxfrequency,
   input  logic [31:0]                       parent_frequency,
   clock_node_freq_sequencer_if.master       div_bus,
   output logic [31:0]                       node_frequency,
   output logic [31:0]                       node_frequency_setting,
   output logic                              busy,
   output logic                              error
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CHECK  = 3'd1;
   localparam logic [2:0] ST_DIVIDE = 3'd2;
   localparam logic [2:0] ST_LOAD   = 3'd3;
   localparam logic [2:0] ST_SETTLE = 3'd4;

   logic [2:0]  state_reg;
   logic [31:0] target_reg;
   logic [31:0] last_override_reg;
   logic [31:0] dividend_reg;
   logic [31:0] rem_reg;
   logic [31:0] quot_reg;
   logic [4:0]  bit_cnt_reg;
   logic [7:0]  settle_cnt_reg;
   logic [15:0] div_value_reg;
   logic        div_load_reg;
   logic [31:0] node_frequency_reg;
   logic [31:0] node_frequency_setting_reg;
   logic        error_reg;

   logic [32:0] rem_shift;
   logic [32:0] rem_diff;
   logic        quot_bit;
   logic [31:0] rem_next;
   logic [31:0] quot_next;
   logic        reject;

   // Only the enable bit and the settle count of node_setting carry meaning.
   logic        unused_setting_bits;
   assign unused_setting_bits = ^{node_setting[31:16], node_setting[7:1]};

   assign reject = (target_reg == 32'd0)
                || (target_reg < node_minfrequency)
                || (target_reg > node_maxfrequency)
                || (target_reg > parent_frequency);

   // One restoring-division step: bring in the next dividend bit, then subtract if it fits.
   always_comb begin
      rem_shift = {rem_reg, dividend_reg[31]};
      rem_diff  = rem_shift - {1'b0, target_reg};
      // No borrow out of bit 32 means the shifted remainder was >= the divisor.
      quot_bit  = ~rem_diff[32];
      rem_next  = quot_bit ? rem_diff[31:0] : rem_shift[31:0];
      quot_next = {quot_reg[30:0], quot_bit};
   end

   // Sequencer FSM with its divider and settle datapath.
   always_ff @(posedge clock or negedge async_resetn) begin
      if (!async_resetn) begin
         state_reg                  <= ST_IDLE;
         target_reg                 <= 32'd0;
         last_override_reg          <= 32'd0;
         dividend_reg               <= 32'd0;
         rem_reg                    <= 32'd0;
         quot_reg                   <= 32'd0;
         bit_cnt_reg                <= 5'd0;
         settle_cnt_reg             <= 8'd0;
         div_value_reg              <= 16'd1;
         div_load_reg               <= 1'b0;
         node_frequency_reg         <= 32'd0;
         node_frequency_setting_reg <= 32'd0;
         error_reg                  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // The override is compared only while idle.
               // The most recent value therefore wins over any values seen while busy.
               if (node_setting[0] && (node_frequency_override != last_override_reg)) begin
                  target_reg        <= node_frequency_override;
                  last_override_reg <= node_frequency_override;
                  state_reg         <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (reject) begin
                  error_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  node_frequency_setting_reg <= target_reg;
                  dividend_reg               <= parent_frequency;
                  rem_reg                    <= 32'd0;
                  quot_reg                   <= 32'd0;
                  bit_cnt_reg                <= 5'd0;
                  state_reg                  <= ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               rem_reg      <= rem_next;
               quot_reg     <= quot_next;
               dividend_reg <= {dividend_reg[30:0], 1'b0};
               bit_cnt_reg  <= bit_cnt_reg + 5'd1;
               // The last step decides on the freshly completed quotient.
               if (bit_cnt_reg == 5'd31) begin
                  if (|quot_next[31:16]) begin
                     error_reg <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else begin
                     div_value_reg <= quot_next[15:0];
                     div_load_reg  <= 1'b1;
                     state_reg     <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (div_bus.div_ack) begin
                  div_load_reg   <= 1'b0;
                  settle_cnt_reg <= node_setting[15:8];
                  state_reg      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // A count of 0 or 1 both spend exactly one cycle here.
               if (settle_cnt_reg <= 8'd1) begin
                  node_frequency_reg <= target_reg;
                  error_reg          <= 1'b0;
                  state_reg          <= ST_IDLE;
               end else begin
                  settle_cnt_reg <= settle_cnt_reg - 8'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign div_bus.div_value      = div_value_reg;
   assign div_bus.div_load       = div_load_reg;
   assign node_frequency         = node_frequency_reg;
   assign node_frequency_setting = node_frequency_setting_reg;
   assign busy                   = (state_reg != ST_IDLE);
   assign error                  = error_reg;

endmodule

// File: tb/tb_clock_node_freq_sequencer.sv
// Directed bench for the clock node frequency sequencer.
// Outputs are sampled on the falling edge. Inputs change on the falling edge.
module tb_clock_node_freq_sequencer;

   logic        clock;
   logic        async_resetn;
   logic [31:0] node_setting;
   logic [31:0] node_frequency_override;
   logic [31:0] node_minfrequency;
   logic [31:0] node_maxfrequency;
   logic [31:0] parent_frequency;
   logic [31:0] node_frequency;
   logic [31:0] node_frequency_setting;
   logic        busy;
   logic        error;

   int total;
   int bad;

   clock_node_freq_sequencer_if div_bus ();

   clock_node_freq_sequencer dut (
      .clock                   (clock),
      .async_resetn            (async_resetn),
      .node_setting            (node_setting),
      .node_frequency_override (node_frequency_override),
      .node_minfrequency       (node_minfrequency),
      .node_maxfrequency       (node_maxfrequency),
      .parent_frequency        (parent_frequency),
      .div_bus                 (div_bus),
      .node_frequency          (node_frequency),
      .node_frequency_setting  (node_frequency_setting),
      .busy                    (busy),
      .error                   (error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Advance falling edges until div_load is seen, or until the budget is spent.
   task automatic wait_load(input int budget, output int cyc);
      cyc = 0;
      while (div_bus.div_load !== 1'b1 && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   // Advance falling edges until busy drops, noting any div_load seen on the way.
   task automatic wait_idle(input int budget, output int cyc, output logic saw_load);
      cyc      = 0;
      saw_load = 1'b0;
      while (busy !== 1'b0 && cyc < budget) begin
         @(negedge clock);
         cyc++;
         if (div_bus.div_load === 1'b1) saw_load = 1'b1;
      end
   endtask

   initial begin
      int   cyc;
      int   cyc2;
      logic saw;
      logic stable;

      total = 0;
      bad   = 0;
      async_resetn            = 1'b1;
      div_bus.div_ack         = 1'b0;
      node_setting            = 32'h0000_0401;   // enable, settle 4
      node_frequency_override = 32'd0;
      node_minfrequency       = 32'd1;
      node_maxfrequency       = 32'd50000000;
      parent_frequency        = 32'd100000000;

      // Reset values
      #3 async_resetn = 1'b0;
      #1;
      check("rst_div_value", {16'd0, div_bus.div_value}, 32'd1);
      check("rst_div_load", {31'd0, div_bus.div_load}, 32'd0);
      check("rst_node_freq", node_frequency, 32'd0);
      check("rst_node_setting", node_frequency_setting, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      repeat (2) @(negedge clock);
      async_resetn = 1'b1;

      // Enable set but override still 0: nothing to do
      repeat (3) @(negedge clock);
      check("idle_no_request", {31'd0, busy}, 32'd0);

      // Quotient overflow: 100000000/1000 = 100000
      node_frequency_override = 32'd1000;
      @(negedge clock);
      check("ovf_busy_after_acc", {31'd0, busy}, 32'd1);
      check("ovf_error_early", {31'd0, error}, 32'd0);
      wait_idle(100, cyc, saw);
      check("ovf_cycles", cyc, 32'd33);
      check("ovf_error", {31'd0, error}, 32'd1);
      check("ovf_div_value", {16'd0, div_bus.div_value}, 32'd1);
      check("ovf_no_load", {31'd0, saw}, 32'd0);

      // Nominal: 100 MHz / 25 MHz = 4, ack two cycles after load
      node_minfrequency       = 32'd1000000;
      node_frequency_override = 32'd25000000;
      @(negedge clock);
      wait_load(100, cyc);
      check("nom_load_latency", cyc, 32'd33);
      check("nom_div_value", {16'd0, div_bus.div_value}, 32'd4);
      check("nom_setting", node_frequency_setting, 32'd25000000);
      @(negedge clock);
      check("nom_load_held", {31'd0, div_bus.div_load}, 32'd1);
      div_bus.div_ack = 1'b1;
      @(negedge clock);
      div_bus.div_ack = 1'b0;
      check("nom_load_dropped", {31'd0, div_bus.div_load}, 32'd0);
      check("nom_freq_before", node_frequency, 32'd0);
      wait_idle(50, cyc, saw);
      check("nom_settle_cycles", cyc, 32'd4);
      check("nom_node_freq", node_frequency, 32'd25000000);
      check("nom_error_cleared", {31'd0, error}, 32'd0);
      @(negedge clock);
      check("nom_stay_idle", {31'd0, busy}, 32'd0);

      // Above max: rejected in CHECK
      node_frequency_override = 32'd60000000;
      @(negedge clock);
      check("rej_busy_check", {31'd0, busy}, 32'd1);
      @(negedge clock);
      check("rej_busy_done", {31'd0, busy}, 32'd0);
      check("rej_error", {31'd0, error}, 32'd1);
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (div_bus.div_load === 1'b1 || busy === 1'b1) saw = 1'b1;
      end
      check("rej_no_load", {31'd0, saw}, 32'd0);
      check("rej_node_freq", node_frequency, 32'd25000000);
      check("rej_div_value", {16'd0, div_bus.div_value}, 32'd4);
      check("rej_setting", node_frequency_setting, 32'd25000000);

      // Overrides changed during DIVIDE: only the latest one is taken up afterwards
      node_frequency_override = 32'd20000000;
      @(negedge clock);
      repeat (5) @(negedge clock);
      node_frequency_override = 32'd10000000;
      repeat (5) @(negedge clock);
      node_frequency_override = 32'd12500000;
      wait_load(100, cyc);
      check("lw_first_div", {16'd0, div_bus.div_value}, 32'd5);
      div_bus.div_ack = 1'b1;
      @(negedge clock);
      div_bus.div_ack = 1'b0;
      wait_idle(50, cyc, saw);
      check("lw_first_freq", node_frequency, 32'd20000000);
      check("lw_error_cleared", {31'd0, error}, 32'd0);
      check("lw_idle_gap", {31'd0, busy}, 32'd0);
      @(negedge clock);
      check("lw_second_start", {31'd0, busy}, 32'd1);
      wait_load(100, cyc);
      check("lw_second_div", {16'd0, div_bus.div_value}, 32'd8);
      check("lw_second_setting", node_frequency_setting, 32'd12500000);
      div_bus.div_ack = 1'b1;
      @(negedge clock);
      div_bus.div_ack = 1'b0;
      wait_idle(50, cyc, saw);
      check("lw_second_freq", node_frequency, 32'd12500000);
      saw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (busy === 1'b1) saw = 1'b1;
      end
      check("lw_no_third", {31'd0, saw}, 32'd0);

      // Ack withheld for 100 cycles: load and value must hold steady
      node_frequency_override = 32'd50000000;
      @(negedge clock);
      wait_load(100, cyc);
      stable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (div_bus.div_load !== 1'b1 || div_bus.div_value !== 16'd2) stable = 1'b0;
      end
      check("hold_stable", {31'd0, stable}, 32'd1);
      div_bus.div_ack = 1'b1;
      @(negedge clock);
      div_bus.div_ack = 1'b0;
      wait_idle(50, cyc2, saw);
      check("hold_done_cycles", cyc2 + 1, 32'd5);
      check("hold_node_freq", node_frequency, 32'd50000000);

      // Reset in the middle of DIVIDE, then the same override restarts (settle count 0)
      node_setting            = 32'h0000_0001;
      node_frequency_override = 32'd40000000;
      @(negedge clock);
      repeat (10) @(negedge clock);
      async_resetn = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_div_value", {16'd0, div_bus.div_value}, 32'd1);
      check("mid_rst_div_load", {31'd0, div_bus.div_load}, 32'd0);
      check("mid_rst_node_freq", node_frequency, 32'd0);
      check("mid_rst_setting", node_frequency_setting, 32'd0);
      check("mid_rst_error", {31'd0, error}, 32'd0);
      @(negedge clock);
      async_resetn = 1'b1;
      @(negedge clock);
      check("restart_busy", {31'd0, busy}, 32'd1);
      wait_load(100, cyc);
      check("restart_latency", cyc, 32'd33);
      check("restart_div", {16'd0, div_bus.div_value}, 32'd2);
      div_bus.div_ack = 1'b1;
      @(negedge clock);
      div_bus.div_ack = 1'b0;
      wait_idle(50, cyc2, saw);
      check("n0_done_cycles", cyc2 + 1, 32'd2);
      check("restart_node_freq", node_frequency, 32'd40000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
